// File: rtl/mem_bus_arbiter.sv
// Purpose: shares one synchronous-read memory between the CPU (default owner) and a loader port.
// Latency: loader grant 1+HOLD_LAT cycles after request; each loader access is acked one cycle later.
// Backpressure: the loader stalls the CPU via cpu_hold; bursts of MAX_BURST force CPU_SLOTS CPU cycles.
module mem_bus_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int HOLD_LAT  = 1,
    parameter int MAX_BURST = 16,
    parameter int CPU_SLOTS = 1
) (
    input  logic              clk,
    input  logic              res,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_wren,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_hold,
    input  logic              ldr_req,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    input  logic              ldr_wren,
    output logic              ldr_gnt,
    output logic              ldr_ack,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int BW = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {S_CPU, S_DRAIN, S_LDR, S_YIELD} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [BW-1:0]     burst_q, burst_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              ldr_gnt_q, ldr_gnt_d;
    logic              ldr_ack_q, ldr_ack_d;
    logic              cpu_own_q, cpu_own_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] ldr_rdata_q, ldr_rdata_d;
    logic              ldr_access;

    assign ldr_access = (state_q == S_LDR) && ldr_gnt_q && ldr_req;

    assign cpu_hold  = cpu_hold_q;
    assign ldr_gnt   = ldr_gnt_q;
    assign ldr_ack   = ldr_ack_q;
    // Read data bypasses straight from memory the cycle after an owned access, else holds the last value.
    assign cpu_rdata = cpu_own_q ? mem_rdata : cpu_rdata_q;
    assign ldr_rdata = ldr_ack_q ? mem_rdata : ldr_rdata_q;

    // Memory port mux: owner drives the bus; drain keeps the CPU address but blocks writes.
    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_wren  = 1'b0;
        case (state_q)
            S_CPU, S_YIELD: mem_wren = cpu_wren;
            S_LDR: begin
                mem_addr  = ldr_addr;
                mem_wdata = ldr_wdata;
                mem_wren  = ldr_wren && ldr_access;
            end
            default: mem_wren = 1'b0;
        endcase
        if (res) begin
            mem_wren = 1'b0;
        end
    end

    // Next-state and registered-output logic for the ownership FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        burst_d     = burst_q;
        cpu_hold_d  = cpu_hold_q;
        ldr_gnt_d   = ldr_gnt_q;
        ldr_ack_d   = ldr_access;
        cpu_own_d   = (state_q == S_CPU) || (state_q == S_YIELD);
        cpu_rdata_d = cpu_rdata;
        ldr_rdata_d = ldr_rdata;
        case (state_q)
            S_CPU: begin
                if (ldr_req) begin
                    state_d    = S_DRAIN;
                    cpu_hold_d = 1'b1;
                    cnt_d      = 4'd0;
                end
            end
            S_DRAIN: begin
                if (!ldr_req) begin
                    state_d    = S_CPU;
                    cpu_hold_d = 1'b0;
                end else if (cnt_q == 4'(HOLD_LAT - 1)) begin
                    state_d   = S_LDR;
                    ldr_gnt_d = 1'b1;
                    burst_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_LDR: begin
                if (ldr_access) begin
                    burst_d = burst_q + 1'b1;
                end
                // Burst limit wins over a simultaneous request drop.
                if ((MAX_BURST != 0) && ldr_access && (burst_q == BW'(MAX_BURST - 1))) begin
                    state_d    = S_YIELD;
                    cpu_hold_d = 1'b0;
                    ldr_gnt_d  = 1'b0;
                    cnt_d      = 4'd0;
                end else if (!ldr_req) begin
                    state_d    = S_CPU;
                    cpu_hold_d = 1'b0;
                    ldr_gnt_d  = 1'b0;
                end
            end
            S_YIELD: begin
                if (cnt_q == 4'(CPU_SLOTS - 1)) begin
                    if (ldr_req) begin
                        state_d    = S_DRAIN;
                        cpu_hold_d = 1'b1;
                        cnt_d      = 4'd0;
                    end else begin
                        state_d = S_CPU;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d    = S_CPU;
                cpu_hold_d = 1'b0;
                ldr_gnt_d  = 1'b0;
            end
        endcase
    end

    // State register with synchronous reset; reset also drops any pending ack.
    always_ff @(posedge clk) begin
        if (res) begin
            state_q     <= S_CPU;
            cnt_q       <= 4'd0;
            burst_q     <= '0;
            cpu_hold_q  <= 1'b0;
            ldr_gnt_q   <= 1'b0;
            ldr_ack_q   <= 1'b0;
            cpu_own_q   <= 1'b0;
            cpu_rdata_q <= '0;
            ldr_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            burst_q     <= burst_d;
            cpu_hold_q  <= cpu_hold_d;
            ldr_gnt_q   <= ldr_gnt_d;
            ldr_ack_q   <= ldr_ack_d;
            cpu_own_q   <= cpu_own_d;
            cpu_rdata_q <= cpu_rdata_d;
            ldr_rdata_q <= ldr_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Purpose: self-checking bench for mem_bus_arbiter with a synchronous-read memory model.
// Latency: loader read data is scored against a queue filled when each access is issued.
// Backpressure: hold/grant timing is checked cycle by cycle against hand-written schedules.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        res;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_wren;
    logic [7:0]  cpu_rdata;
    logic        cpu_hold;
    logic        ldr_req;
    logic [15:0] ldr_addr;
    logic [7:0]  ldr_wdata;
    logic        ldr_wren;
    logic        ldr_gnt;
    logic        ldr_ack;
    logic [7:0]  ldr_rdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_wren;
    logic [7:0]  mem_rdata;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .ADDR_W(16), .DATA_W(8), .HOLD_LAT(1), .MAX_BURST(4), .CPU_SLOTS(1)
    ) u_dut (
        .clk(clk), .res(res),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wren(cpu_wren),
        .cpu_rdata(cpu_rdata), .cpu_hold(cpu_hold),
        .ldr_req(ldr_req), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata), .ldr_wren(ldr_wren),
        .ldr_gnt(ldr_gnt), .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
        .mem_rdata(mem_rdata)
    );

    // Synchronous read-first memory; known contents are loaded while reset is high.
    logic [7:0] mem [0:65535];
    always @(posedge clk) begin
        mem_rdata <= mem[mem_addr];
        if (res) begin
            mem[16'h0000] <= 8'h00;
            mem[16'h0100] <= 8'h00;
            for (int i = 0; i < 10; i++) mem[16'h0200 + i] <= 8'hC0 + 8'(i);
        end else if (mem_wren) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    int         tests   = 0;
    int         fails   = 0;
    int         ack_cnt = 0;
    bit         done    = 1'b0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        res = 1'b1; cpu_addr = 16'h0; cpu_wdata = 8'h0; cpu_wren = 1'b1;
        ldr_req = 1'b0; ldr_addr = 16'h0; ldr_wdata = 8'h0; ldr_wren = 1'b0;
        fork
            // Monitor: every ack pops one expected loader read value.
            begin
                while (!done) begin
                    @(negedge clk);
                    if (ldr_ack) begin
                        ack_cnt++;
                        if (exp_q.size() == 0) begin
                            tests++;
                            fails++;
                            $display("FAIL ldr_ack_unexpected: ack with rdata 0x%0h, expected no ack", ldr_rdata);
                        end else begin
                            check("ldr_rdata", {24'h0, ldr_rdata}, {24'h0, exp_q.pop_front()});
                        end
                    end
                end
            end
            // Stimulus
            begin
                logic [17:0] gnt_exp;
                logic [17:0] hold_exp;
                int          a0;
                int          n;
                tick; tick;
                #1;
                check("rst_hold", cpu_hold, 0);
                check("rst_gnt", ldr_gnt, 0);
                check("rst_ack", ldr_ack, 0);
                check("rst_cpu_rdata", cpu_rdata, 0);
                check("rst_ldr_rdata", ldr_rdata, 0);
                check("rst_mem_wren", mem_wren, 0);

                // Test 1: idle loader, CPU write then read
                res = 1'b0; cpu_addr = 16'h0010; cpu_wdata = 8'h5A; cpu_wren = 1'b1;
                #1;
                check("t1_mem_wren_w", mem_wren, 1);
                check("t1_mem_addr", mem_addr, 16'h0010);
                check("t1_mem_wdata", mem_wdata, 8'h5A);
                tick; cpu_wren = 1'b0; #1;
                check("t1_mem_wren_r", mem_wren, 0);
                check("t1_hold", cpu_hold, 0);
                tick;
                check("t1_cpu_rdata", cpu_rdata, 8'h5A);
                check("t1_hold2", cpu_hold, 0);

                // Test 2/3: loader write then read of 0x0100
                tick;
                ldr_req = 1'b1; ldr_addr = 16'h0100; ldr_wdata = 8'hA5; ldr_wren = 1'b1;
                cpu_wren = 1'b1; #1;
                check("t2_c0_hold", cpu_hold, 0);
                check("t2_c0_gnt", ldr_gnt, 0);
                check("t2_c0_mem_wren", mem_wren, 1);
                tick;
                check("t2_c1_hold", cpu_hold, 1);
                check("t2_c1_gnt", ldr_gnt, 0);
                check("t2_c1_mem_wren", mem_wren, 0);
                check("t2_c1_cpu_rdata", cpu_rdata, 8'h5A);
                tick; cpu_wren = 1'b0; exp_q.push_back(8'h00); #1;
                check("t2_c2_gnt", ldr_gnt, 1);
                check("t2_c2_hold", cpu_hold, 1);
                check("t2_c2_ack", ldr_ack, 0);
                check("t2_c2_mem_addr", mem_addr, 16'h0100);
                check("t2_c2_mem_wren", mem_wren, 1);
                check("t2_c2_cpu_rdata", cpu_rdata, 8'h5A);
                tick; ldr_wren = 1'b0; exp_q.push_back(8'hA5); #1;
                check("t2_c3_ack", ldr_ack, 1);
                check("t3_c3_cpu_rdata", cpu_rdata, 8'h5A);
                tick; ldr_req = 1'b0; #1;
                check("t3_c4_ack", ldr_ack, 1);
                check("t3_c4_gnt", ldr_gnt, 1);
                check("t3_c4_cpu_rdata", cpu_rdata, 8'h5A);
                tick;
                check("t3_c5_gnt", ldr_gnt, 0);
                check("t3_c5_hold", cpu_hold, 0);
                check("t3_c5_ack", ldr_ack, 0);

                // Test 6: one-cycle request pulse aborts in drain
                tick; ldr_req = 1'b1; #1;
                check("t6_c0_hold", cpu_hold, 0);
                tick; ldr_req = 1'b0; #1;
                check("t6_c1_hold", cpu_hold, 1);
                check("t6_c1_gnt", ldr_gnt, 0);
                tick;
                check("t6_c2_hold", cpu_hold, 0);
                check("t6_c2_gnt", ldr_gnt, 0);
                tick;
                check("t6_c3_hold", cpu_hold, 0);
                check("t6_c3_gnt", ldr_gnt, 0);

                // Test 4: burst limit 4, ten loader reads
                gnt_exp  = 18'b011100111100111100;
                hold_exp = 18'b011110111110111110;
                a0 = ack_cnt;
                n  = 0;
                cpu_addr = 16'h0010; cpu_wren = 1'b0; ldr_wren = 1'b0;
                for (int c = 0; c < 18; c++) begin
                    tick;
                    ldr_req = (c <= 15);
                    if (gnt_exp[c] && ldr_req) begin
                        ldr_addr = 16'h0200 + 16'(n);
                        exp_q.push_back(8'hC0 + 8'(n));
                        n++;
                    end
                    #1;
                    check($sformatf("t4_gnt_c%0d", c), ldr_gnt, gnt_exp[c]);
                    check($sformatf("t4_hold_c%0d", c), cpu_hold, hold_exp[c]);
                    if (c == 6 || c == 12) check($sformatf("t4_yield_addr_c%0d", c), mem_addr, 16'h0010);
                end
                tick; tick;
                check("t4_ack_total", ack_cnt - a0, 10);

                // Test 5: reset in the middle of a loader grant
                tick; ldr_req = 1'b1; ldr_wren = 1'b1; ldr_addr = 16'h0300; ldr_wdata = 8'hEE; #1;
                check("t5_c0_hold", cpu_hold, 0);
                tick;
                check("t5_c1_hold", cpu_hold, 1);
                tick; res = 1'b1; cpu_wren = 1'b1; #1;
                check("t5_c2_gnt", ldr_gnt, 1);
                check("t5_c2_mem_wren", mem_wren, 0);
                tick; ldr_req = 1'b0; #1;
                check("t5_c3_hold", cpu_hold, 0);
                check("t5_c3_gnt", ldr_gnt, 0);
                check("t5_c3_ack", ldr_ack, 0);
                check("t5_c3_mem_wren", mem_wren, 0);
                check("t5_c3_cpu_rdata", cpu_rdata, 0);
                tick; res = 1'b0; cpu_wren = 1'b0; cpu_addr = 16'h0010; #1;
                check("t5_c4_mem_addr", mem_addr, 16'h0010);
                check("t5_c4_hold", cpu_hold, 0);
                tick;
                check("t5_c5_cpu_rdata", cpu_rdata, 8'h5A);
                check("t5_c5_gnt", ldr_gnt, 0);

                tick; tick;
                check("queue_empty", exp_q.size(), 0);
                done = 1'b1;
            end
        join
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
